// File: rtl/disp_pkg.sv
// Shared constants and helpers for the N-channel dispatcher.
package disp_pkg;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_UNF   = 2'b10;
  localparam logic [1:0] ERR_BADID = 2'b11;

  // Ceiling log2; usable in constant expressions for pointer widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_fifo_ch.sv
// One dispatcher channel: circular FIFO with occupancy flags, output register
// and a sticky error code.
module disp_fifo_ch
  import disp_pkg::*;
#(
  parameter int unsigned MAIN_SIZE    = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AF_THR       = DEPTH - 1,
  parameter int unsigned AE_THR       = 1,
  parameter bit          DROP_ON_FULL = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [MAIN_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 clear_err,
  input  logic                 bad_id,
  output logic [MAIN_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [1:0]           error
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [MAIN_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_rd, do_wr, pop, unf, ovf;
  logic [1:0]           new_err, err_d;

  assign empty        = (count_q == CW'(0));
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(AE_THR));
  assign almost_full  = (count_q >= CW'(AF_THR));

  // Overflow only when full and no same-cycle read frees a slot.
  always_comb begin
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    pop     = 1'b0;
    unf     = 1'b0;
    ovf     = 1'b0;
    new_err = ERR_NONE;
    err_d   = error;
    count_d = count_q;

    do_rd = rd_en && !empty;
    unf   = rd_en && empty;
    ovf   = wr_en && full && !rd_en;
    do_wr = wr_en && !(ovf && DROP_ON_FULL);
    pop   = do_rd || (ovf && !DROP_ON_FULL);

    if (ovf)         new_err = ERR_OVF;
    else if (unf)    new_err = ERR_UNF;
    else if (bad_id) new_err = ERR_BADID;

    if (new_err != ERR_NONE && (error == ERR_NONE || clear_err)) err_d = new_err;
    else if (clear_err)                                          err_d = ERR_NONE;

    count_d = count_q + CW'(do_wr) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      error    <= ERR_NONE;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_rd) rd_data  <= mem[rd_ptr_q];
      rd_valid <= do_rd;
      count_q  <= count_d;
      error    <= err_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/disp_nch.sv
// N-channel dispatcher: decodes the channel-ID header into per-channel FIFO
// writes; out-of-range IDs raise the bad-id code on channel 0.
module disp_nch
  import disp_pkg::*;
#(
  parameter int unsigned MAIN_SIZE    = 8,
  parameter int unsigned CH_BITS      = 2,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AF_THR       = DEPTH - 1,
  parameter int unsigned AE_THR       = 1,
  parameter bit          DROP_ON_FULL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MAIN_SIZE+CH_BITS-1:0]  in,
  input  logic                          in_valid,
  input  logic [NUM_CH-1:0]             read,
  input  logic [NUM_CH-1:0]             clear_err,
  output logic [NUM_CH*MAIN_SIZE-1:0]   out,
  output logic [NUM_CH-1:0]             out_valid,
  output logic [NUM_CH-1:0]             empty,
  output logic [NUM_CH-1:0]             full,
  output logic [NUM_CH-1:0]             almost_empty,
  output logic [NUM_CH-1:0]             almost_full,
  output logic [2*NUM_CH-1:0]           error
);

  logic [CH_BITS-1:0]   id;
  logic [MAIN_SIZE-1:0] payload;
  logic                 bad;
  logic [NUM_CH-1:0]    wr_en;
  logic [NUM_CH-1:0]    bad_ch;

  assign id      = in[MAIN_SIZE+CH_BITS-1:MAIN_SIZE];
  assign payload = in[MAIN_SIZE-1:0];
  // Extra bit so the compare also works when NUM_CH == 2**CH_BITS.
  assign bad     = in_valid && ({1'b0, id} >= (CH_BITS+1)'(NUM_CH));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr_en[k]  = in_valid && (id == CH_BITS'(k));
    assign bad_ch[k] = (k == 0) ? bad : 1'b0;

    disp_fifo_ch #(
      .MAIN_SIZE    (MAIN_SIZE),
      .DEPTH        (DEPTH),
      .AF_THR       (AF_THR),
      .AE_THR       (AE_THR),
      .DROP_ON_FULL (DROP_ON_FULL)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en[k]),
      .wr_data      (payload),
      .rd_en        (read[k]),
      .clear_err    (clear_err[k]),
      .bad_id       (bad_ch[k]),
      .rd_data      (out[k*MAIN_SIZE +: MAIN_SIZE]),
      .rd_valid     (out_valid[k]),
      .empty        (empty[k]),
      .full         (full[k]),
      .almost_empty (almost_empty[k]),
      .almost_full  (almost_full[k]),
      .error        (error[2*k +: 2])
    );
  end

endmodule

// File: doc/disp_nch.md
# disp_nch

Parametrised N-channel dispatcher with per-channel FIFO buffering. It is the successor to the fixed two-channel, four-deep dispatcher. Each input word carries a channel-ID header above its payload. The block steers the payload into that channel's FIFO and drains each FIFO independently on its read strobe. It adds threshold flags, per-channel sticky error codes and a configurable overflow policy. It sits between the serial-to-parallel front end and the per-lane consumers of the PCIe switching datapath.

## Interface
- MAIN_SIZE, 8: payload width in bits.
- CH_BITS, 2: header width; the channel ID is in[MAIN_SIZE+CH_BITS-1:MAIN_SIZE].
- NUM_CH, 4: channels instantiated, 2..2^CH_BITS.
- DEPTH, 4: entries per FIFO; must be a power of two, 2..64.
- AF_THR, DEPTH-1: almost_full asserts at occupancy >= AF_THR.
- AE_THR, 1: almost_empty asserts at occupancy <= AE_THR.
- DROP_ON_FULL, 1: 1 = drop a write to a full FIFO and flag it; 0 = overwrite the oldest entry and flag it.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low.
- in  in  MAIN_SIZE+CH_BITS  header and payload.
- in_valid  in  1  in is written this cycle.
- read  in  NUM_CH  per-channel pop strobe.
- clear_err  in  NUM_CH  per-channel synchronous clear of the error code.
- out  out  NUM_CH*MAIN_SIZE  registered data; channel k occupies bits [k*MAIN_SIZE +: MAIN_SIZE].
- out_valid  out  NUM_CH  one-cycle pulse, channel k out is new.
- empty, full, almost_empty, almost_full  out  NUM_CH each  occupancy flags.
- error  out  2*NUM_CH  per-channel code: 00 none, 01 overflow, 10 underflow, 11 bad-id.

## Operation
- Reset (async assert, sync release): all pointers and counts go to 0. out=0, out_valid=0, error=0, empty=1, almost_empty=1, full=0, almost_full=0.
- Write: in_valid=1 with ID < NUM_CH writes the payload into FIFO[ID].
- Bad ID: in_valid=1 with ID >= NUM_CH stores nothing and sets error code 11 on channel 0.
- Read: read[k]=1 with FIFO k non-empty pops the head entry into out[k] and pulses out_valid[k] on the next cycle. out[k] holds its value otherwise.
- Underflow: read[k] on an empty FIFO leaves data unchanged, gives no out_valid and sets code 10.
- Full FIFO, write without a same-cycle read:
  - DROP_ON_FULL=1: the write is dropped and code 01 is set.
  - DROP_ON_FULL=0: the head is discarded, the new word is written, count stays at DEPTH, and code 01 is set.
- Full FIFO with a same-cycle read and write: both proceed, count is unchanged and no error is raised.
- Empty FIFO with a same-cycle read and write: the write is stored, underflow is flagged, and there is no fall-through.
- Error codes are sticky. The first error wins until clear_err[k]. If clear_err and a new error occur in the same cycle, the new error is kept.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits. Flags are decoded combinationally from the registered count.

## Timing
- Write to flag update: 1 cycle. The entry is visible to a read on the cycle after it is written.
- Read to out/out_valid: 1 cycle.
- Minimum write-to-out latency: 2 cycles.
- Throughput: 1 write per cycle total, plus 1 read per channel per cycle.
- Reset asserted mid-operation: all state clears immediately, with no dependency on clk. In-flight data is lost.

## Structure
- Package disp_pkg:
  - error-code localparams ERR_NONE, ERR_OVF, ERR_UNF, ERR_BADID;
  - a clog2 function.
- Sub-module disp_fifo_ch:
  - one FIFO with count, flags, read register and error code;
  - instantiated NUM_CH times in a generate loop.
- Top level: ID decode into per-channel write enables, plus bad-ID error injection into channel 0.

## Test plan
- Route: write ID0..3 with payloads A0, B1, C2, D3, then read all channels. Required: each out[k] holds its payload, with out_valid pulses 1 cycle after each read.
- Fill and overflow (DEPTH=4, DROP_ON_FULL=1):
  - write 5 words to channel 2;
  - required: full=1 after the fourth write, the fifth word is absent on readback, error[2]=01;
  - then clear_err[2]: error[2]=00.
- Overwrite (DROP_ON_FULL=0): write 0x10..0x14 to channel 1, then read 4. Required: out sequence 0x11, 0x12, 0x13, 0x14.
- Underflow and simultaneous events:
  - read an empty channel 3: error[3]=10, no out_valid;
  - read+write on a full channel: count unchanged, no error.
- Bad ID (NUM_CH=3, CH_BITS=2): write ID 3. Required: no FIFO changes, error[0]=11.
- Async reset mid-burst: drop reset between clock edges. Required: all outputs reach their reset values before the next edge, and empty is all-ones.
